input_conditioner: RTL and testbench

Parametrised N-channel front end for raw push-button and switch inputs. Per channel it synchronises the input, debounces it on a shared prescaled sample tick, and produces a clean level, one-cycle rise/fall pulses, a toggle state and a sticky event flag with per-channel clear. It sits directly behind the board pins and replaces ad-hoc synchronizer/debouncer/flip-flop instances in top-level designs.

---
 rtl/input_conditioner_pkg.sv | 21 ++
 rtl/input_conditioner_ch.sv | 125 ++++++++++++
 rtl/input_conditioner.sv | 64 ++++++
 tb/tb_input_conditioner.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared types and width helpers for the input conditioner.
// Debounce states and counter sizing used by the top and the per-channel slice.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } db_state_t;

    // Prescaler counts 0..div-1; a one-bit counter is kept even when div is 1.
    function automatic int pre_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

    function automatic int cnt_width(input int stable);
        return (stable < 1) ? 1 : $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// One input channel: synchroniser, tick-driven debounce FSM, and the
// rise/fall pulse, toggle and sticky-event registers derived from it.
module input_conditioner_ch
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic in_i,
    input  logic clr_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic toggle_o,
    output logic evt_o
);

    localparam int CNT_W = cnt_width(STABLE_TICKS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   cnt_done;
    logic                   rise_q, rise_d, fall_q, fall_d;
    logic                   toggle_q, toggle_d, evt_q, evt_d;

    assign s        = sync_q[SYNC_STAGES-1];
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign cnt_done = (cnt_inc == CNT_W'(STABLE_TICKS));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick_i) begin
            case (state_q)
                ST_LO: begin
                    if (s) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = ST_HI;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = CHK_HI;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        state_d = ST_LO;
                        cnt_d   = '0;
                    end else if (cnt_done) begin
                        state_d = ST_HI;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_HI: begin
                    if (!s) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = ST_LO;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = CHK_LO;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        state_d = ST_HI;
                        cnt_d   = '0;
                    end else if (cnt_done) begin
                        state_d = ST_LO;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end
            endcase
        end
        toggle_d = toggle_q ^ rise_d;
        // A rise already on the output beats a concurrent clear.
        evt_d    = rise_q | (evt_q & ~clr_i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            state_q  <= ST_LO;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            toggle_q <= 1'b0;
            evt_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], in_i};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            toggle_q <= toggle_d;
            evt_q    <= evt_d;
        end
    end

    assign level_o  = (state_q == ST_HI) || (state_q == CHK_LO);
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign toggle_o = toggle_q;
    assign evt_o    = evt_q;

endmodule

// File: rtl/input_conditioner.sv
// N-channel push-button/switch front end: one shared sample-tick prescaler
// feeding an independent conditioning slice per input pin.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in_i,
    input  logic [N_CH-1:0] clr_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] toggle_o,
    output logic [N_CH-1:0] evt_o,
    output logic            tick_o
);

    localparam int               PRE_W    = pre_width(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;

    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // With TICK_DIV=1 the compare is always true, so mask it while in reset.
    assign tick_o = tick & rst;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        input_conditioner_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_TICKS(STABLE_TICKS)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick_i  (tick),
            .in_i    (in_i[gi]),
            .clr_i   (clr_i[gi]),
            .level_o (level_o[gi]),
            .rise_o  (rise_o[gi]),
            .fall_o  (fall_o[gi]),
            .toggle_o(toggle_o[gi]),
            .evt_o   (evt_o[gi])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: a vector table for the per-channel
// behaviour plus hand sequences for latency, clear priority and mid-debounce reset.
module tb_input_conditioner;

    localparam int N_CH = 4, SYNC_STAGES = 2, TICK_DIV = 4, STABLE_TICKS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] in_i = '0, clr_i = '0;
    logic [3:0] level_o, rise_o, fall_o, toggle_o, evt_o;
    logic       tick_o;

    input_conditioner #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES),
        .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .in_i(in_i), .clr_i(clr_i),
        .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
        .toggle_o(toggle_o), .evt_o(evt_o), .tick_o(tick_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  in;
        logic [3:0]  clr;
        logic [7:0]  ncyc;
        logic [3:0]  level;
        logic [3:0]  toggle;
        logic [3:0]  evt;
        logic [15:0] rn;   // expected rise count per channel, one nibble each
        logic [15:0] fn;
    } row_t;

    int         errors = 0, checks = 0, cyc = 0, mon_bad = 0;
    int         rcnt[4], fcnt[4];
    logic [3:0] prev_level = '0;
    row_t       rows[14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
        else $display("ok   %s = 0x%0h (cyc %0d)", name, got, cyc);
    endtask

    task automatic chk_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
        end
        else $display("ok   %s = %0d", name, val);
    endtask

    task automatic clear_counts();
        for (int c = 0; c < 4; c++) begin
            rcnt[c] = 0;
            fcnt[c] = 0;
        end
        mon_bad = 0;
    endtask

    // One clock; sample after the edge and track pulses, level/pulse agreement and tick phase.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < 4; c++) begin
            if (rise_o[c]) rcnt[c]++;
            if (fall_o[c]) fcnt[c]++;
        end
        if ((level_o & ~prev_level) !== rise_o) mon_bad++;
        if ((~level_o & prev_level) !== fall_o) mon_bad++;
        if ((rise_o & fall_o) !== 4'b0000) mon_bad++;
        if (tick_o !== ((cyc % 4) == 3)) mon_bad++;
        prev_level = level_o;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        cyc        = 0;
        prev_level = '0;
        clear_counts();
    endtask

    initial begin
        int lat;
        int found;

        // Table: cycle counts assume ticks on edges 4,8,12,... after release.
        rows[0]  = '{4'b0011, 4'b0000, 8'd5,  4'b0001, 4'b0001, 4'b0001, 16'h0000, 16'h0000};
        rows[1]  = '{4'b0001, 4'b0000, 8'd11, 4'b0001, 4'b0001, 4'b0001, 16'h0000, 16'h0000};
        rows[2]  = '{4'b0101, 4'b0000, 8'd3,  4'b0001, 4'b0001, 4'b0001, 16'h0000, 16'h0000};
        rows[3]  = '{4'b0001, 4'b0000, 8'd3,  4'b0001, 4'b0001, 4'b0001, 16'h0000, 16'h0000};
        rows[4]  = '{4'b0101, 4'b0000, 8'd3,  4'b0001, 4'b0001, 4'b0001, 16'h0000, 16'h0000};
        rows[5]  = '{4'b0001, 4'b0000, 8'd3,  4'b0001, 4'b0001, 4'b0001, 16'h0000, 16'h0000};
        rows[6]  = '{4'b0101, 4'b0000, 8'd20, 4'b0101, 4'b0101, 4'b0101, 16'h0100, 16'h0000};
        rows[7]  = '{4'b0001, 4'b0000, 8'd20, 4'b0001, 4'b0101, 4'b0101, 16'h0000, 16'h0100};
        rows[8]  = '{4'b1001, 4'b0000, 8'd16, 4'b1001, 4'b1101, 4'b1101, 16'h1000, 16'h0000};
        rows[9]  = '{4'b0001, 4'b0000, 8'd16, 4'b0001, 4'b1101, 4'b1101, 16'h0000, 16'h1000};
        rows[10] = '{4'b1001, 4'b0000, 8'd16, 4'b1001, 4'b0101, 4'b1101, 16'h1000, 16'h0000};
        rows[11] = '{4'b0001, 4'b0000, 8'd16, 4'b0001, 4'b0101, 4'b1101, 16'h0000, 16'h1000};
        rows[12] = '{4'b0001, 4'b1000, 8'd1,  4'b0001, 4'b0101, 4'b0101, 16'h0000, 16'h0000};
        rows[13] = '{4'b0001, 4'b0000, 8'd2,  4'b0001, 4'b0101, 4'b0101, 16'h0000, 16'h0000};

        // Reset state with activity on the pins.
        in_i = 4'b1010;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {level_o, rise_o, fall_o, toggle_o, evt_o, tick_o}, 32'h0);

        // Channel 0 press right at release: latency window and first outputs.
        in_i = 4'b0000;
        release_reset();
        in_i = 4'b0001;
        lat  = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            step();
            if (level_o[0]) lat = cyc;
        end
        chk_range("ch0_latency", lat, 11, 14);
        chk("ch0_rise_with_level", rise_o, 4'b0001);
        while (cyc < 13) step();
        chk("ch0_rise_one_cycle", rise_o, 4'b0000);
        chk("ch0_level", level_o, 4'b0001);
        chk("ch0_toggle", toggle_o, 4'b0001);
        chk("ch0_evt", evt_o, 4'b0001);
        chk("phaseA_monitor", mon_bad, 0);

        // Table-driven vectors: glitch, bounce, press/release cycles, clear.
        for (int r = 0; r < 14; r++) begin
            in_i  = rows[r].in;
            clr_i = rows[r].clr;
            clear_counts();
            for (int k = 0; k < int'(rows[r].ncyc); k++) step();
            chk($sformatf("row%0d_level", r), level_o, rows[r].level);
            chk($sformatf("row%0d_toggle", r), toggle_o, rows[r].toggle);
            chk($sformatf("row%0d_evt", r), evt_o, rows[r].evt);
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("row%0d_rises_ch%0d", r, c), rcnt[c], 32'(rows[r].rn[c*4 +: 4]));
                chk($sformatf("row%0d_falls_ch%0d", r, c), fcnt[c], 32'(rows[r].fn[c*4 +: 4]));
            end
            chk($sformatf("row%0d_monitor", r), mon_bad, 0);
        end
        clr_i = 4'b0000;

        // Clear priority: clr held across a rise on channel 0.
        clr_i = 4'b0001;
        step();
        clr_i = 4'b0000;
        chk("clr_ch0_evt", evt_o, 4'b0100);
        in_i  = 4'b0000;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (!level_o[0]) found = 1;
        end
        chk("ch0_release_seen", found, 1);
        in_i  = 4'b0001;
        clr_i = 4'b0001;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (rise_o[0]) found = 1;
        end
        chk("rise_under_clr_seen", found, 1);
        chk("evt_before_set", evt_o, 4'b0100);
        step();
        chk("set_wins_evt", evt_o, 4'b0101);
        clr_i = 4'b0000;
        step();
        chk("evt_holds", evt_o, 4'b0101);
        clr_i = 4'b0001;
        step();
        clr_i = 4'b0000;
        chk("evt_cleared", evt_o, 4'b0100);
        step();
        chk("evt_stays_cleared", evt_o, 4'b0100);
        chk("toggle_after_second_rise", toggle_o, 4'b0100);
        chk("clr_seq_monitor", mon_bad, 0);

        // Reset in the middle of a channel 0 debounce.
        in_i  = 4'b0000;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (!level_o[0]) found = 1;
        end
        chk("ch0_low_again", found, 1);
        in_i = 4'b0001;
        repeat (7) step();
        chk("mid_debounce_level", level_o, 4'b0000);
        chk("pre_reset_toggle", toggle_o, 4'b0100);
        rst = 1'b0;
        #2;
        chk("async_reset_outputs", {level_o, rise_o, fall_o, toggle_o, evt_o, tick_o}, 32'h0);
        @(posedge clk);
        release_reset();
        lat = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            step();
            if (level_o[0]) lat = cyc;
        end
        chk_range("post_reset_latency", lat, 11, 14);
        chk("post_reset_rise", rise_o, 4'b0001);
        chk("post_reset_no_fall", fcnt[0], 0);
        chk("post_reset_monitor", mon_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
